// File: rtl/gf7_exp_ctrl.sv
// GF(2^7) exponentiation c = a^e (poly x^7+x+1), MSB-first square-and-multiply on one shared multiplier.
// Optional feature: define GF7_INV_EN to add the in_inv port (e_eff = 126 gives a^-1).

module gf7_mul (
  input  logic [6:0] a,
  input  logic [6:0] b,
  output logic [6:0] p
);
  logic [12:0] prod;

  // NOTE: combinational blocks use blocking '=' so each loop step sees the previous partial result.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) prod = prod ^ ({6'b0, a} << i);
    end
    p = prod[6:0];
    // x^i = x^(i-7) * (x + 1) for i >= 7; terms never reach bit 7 again, so one pass suffices.
    for (int i = 7; i < 13; i++) begin
      if (prod[i]) begin
        p[i-7] = p[i-7] ^ 1'b1;
        p[i-6] = p[i-6] ^ 1'b1;
      end
    end
  end
endmodule

module gf7_exp_ctrl #(
  parameter int EXP_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_a,
  input  logic [EXP_W-1:0] in_e,
`ifdef GF7_INV_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_c,
  output logic             busy
);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_DONE} state_t;

  state_t           state, state_nx;
  logic [6:0]       a_r, acc;
  logic [EXP_W-1:0] e_r, e_eff;
  logic [IDX_W-1:0] idx;
  logic             idx_dec;
  logic [6:0]       mul_b, mul_p;

`ifdef GF7_INV_EN
  assign e_eff = in_inv ? EXP_W'(126) : in_e;
`else
  assign e_eff = in_e;
`endif

  assign mul_b = (state == S_MUL) ? a_r : acc;

  gf7_mul u_mul (
    .a (acc),
    .b (mul_b),
    .p (mul_p)
  );

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    idx_dec  = 1'b0;
    unique case (state)
      S_IDLE: if (in_valid) state_nx = S_SQR;
      S_SQR: begin
        if (e_r[idx])            state_nx = S_MUL;
        else if (idx == '0)      state_nx = S_DONE;
        else                     idx_dec  = 1'b1;
      end
      S_MUL: begin
        if (idx == '0) state_nx = S_DONE;
        else begin
          state_nx = S_SQR;
          idx_dec  = 1'b1;
        end
      end
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      e_r   <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r <= in_a;
            e_r <= e_eff;
            acc <= 7'h01;
            idx <= IDX_W'(EXP_W - 1);
          end
        end
        S_SQR, S_MUL: begin
          acc <= mul_p;
          if (idx_dec) idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_c     = acc;

endmodule

// File: tb/tb_gf7_exp_ctrl.sv
// Self-checking bench for gf7_exp_ctrl: directed cases plus random stimulus against a repeated-multiply model.
// Inverse cases are exercised only when GF7_INV_EN is defined.

module tb_gf7_exp_ctrl;
  localparam int EXP_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [6:0]       in_a = '0;
  logic [EXP_W-1:0] in_e = '0;
  logic             in_inv = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [6:0]       out_c;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gf7_exp_ctrl #(.EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_e      (in_e),
`ifdef GF7_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .busy      (busy)
  );

  // Shift-and-add with xtime reduction (x^7 -> x + 1).
  function automatic logic [6:0] mul_ref(input logic [6:0] a, input logic [6:0] b);
    logic [6:0] r = '0;
    logic [6:0] aa = a;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[6] ? ({aa[5:0], 1'b0} ^ 7'h03) : {aa[5:0], 1'b0};
    end
    return r;
  endfunction

  // a^e as e plain repeated multiplications, with a^0 = 1.
  function automatic logic [6:0] pow_ref(input logic [6:0] a, input int e);
    logic [6:0] r = 7'h01;
    for (int i = 0; i < e; i++) r = mul_ref(r, a);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [6:0] a, input logic [EXP_W-1:0] e, input logic inv);
    @(negedge clk);
    in_a     = a;
    in_e     = e;
    in_inv   = inv;
    in_valid = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_e     = $urandom;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!out_valid && n < 300);
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [6:0] a, input logic [EXP_W-1:0] e,
                        input logic [6:0] exp_c);
    accept(a, e, 1'b0);
    wait_done(tag, EXP_W + $countones(e));
    check({tag, "_out_c"}, out_c, exp_c);
    release_result();
  endtask

  initial begin
    logic [6:0]       ra;
    logic [EXP_W-1:0] re;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_c", out_c, 7'h00);

    run_op("basic_2_7", 7'h02, 7'd7, 7'h03);
    run_op("zero_0_0", 7'h00, 7'd0, 7'h01);
    run_op("zero_0_5", 7'h00, 7'd5, 7'h00);
    run_op("zero_55_0", 7'h55, 7'd0, 7'h01);
    run_op("order_2_127", 7'h02, 7'd127, 7'h01);

    for (int a = 1; a < 128; a++) run_op("sweep_e127", 7'(a), 7'd127, 7'h01);

    for (int i = 0; i < 30; i++) begin
      ra = 7'($urandom);
      re = EXP_W'($urandom);
      run_op("random", ra, re, pow_ref(ra, int'(re)));
    end

    // Backpressure: result held while out_ready is low, and new requests are refused.
    accept(7'h13, 7'h2B, 1'b0);
    wait_done("bp", EXP_W + $countones(7'h2B));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 7'h7F;
      in_e     = 7'h01;
      check("bp_out_c", out_c, pow_ref(7'h13, 7'h2B));
      check("bp_out_valid", out_valid, 1);
      check("bp_busy", busy, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_out_c_final", out_c, pow_ref(7'h13, 7'h2B));
    release_result();
    @(posedge clk);
    #1;
    check("bp_no_accept_busy", busy, 0);

    // Abort mid-computation with a one-cycle reset.
    accept(7'h02, 7'd127, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_c", out_c, 7'h00);
    check("abort_busy", busy, 0);
    run_op("after_abort", 7'h03, 7'h11, pow_ref(7'h03, 17));

`ifdef GF7_INV_EN
    accept(7'h02, 7'd3, 1'b1);
    wait_done("inv_2", EXP_W + 6);
    check("inv_2_out_c", out_c, 7'h41);
    release_result();
    accept(7'h00, 7'd3, 1'b1);
    wait_done("inv_0", EXP_W + 6);
    check("inv_0_out_c", out_c, 7'h00);
    release_result();
    for (int i = 0; i < 10; i++) begin
      ra = 7'($urandom_range(1, 127));
      accept(ra, 7'($urandom), 1'b1);
      wait_done("inv_rand", EXP_W + 6);
      check("inv_rand_product", mul_ref(out_c, ra), 7'h01);
      release_result();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed stuck simulation expected completion");
    $fatal(1, "timeout");
  end

endmodule
